// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory and hands each fetched word plus its PC to decode.
// Redirects from the branch/jump unit squash whatever fetch is in flight.
// Optional build macro FETCH_MISALIGN_CHECK_EN: rejects redirects whose
// target is not word aligned and flags them on redirect_misaligned.

package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module fetch_stage #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            redirect_misaligned
`endif
);

    // REQ: request on the bus, WAIT: response pending, HOLD: word offered to
    // decode, DROP: a squashed request still owes us one response.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_fly;
    logic            req_fire;
    logic            redir_take;
    logic            rsp_in_wait;
    logic [XLEN-1:0] redir_pc_aligned;

    assign redir_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned target is dropped entirely; only aligned redirects act.
    assign redir_take = redirect_valid & (redirect_pc[1:0] == 2'b00);

    // One-cycle flag for a rejected misaligned redirect.
    always_ff @(posedge clk) begin
        if (rst) redirect_misaligned <= 1'b0;
        else     redirect_misaligned <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
`else
    // Low address bits of the target are simply forced to zero.
    assign redir_take = redirect_valid;
`endif

    assign imem_req_valid = (state_q == S_REQ) & ~rst;
    assign imem_req_addr  = pc_q;
    assign inst_valid     = (state_q == S_HOLD) & ~rst;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_in_wait    = (state_q == S_WAIT) & imem_rsp_valid;

    // State, PC bookkeeping and the decode-facing output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pc_fly    <= RESET_PC;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire)
                pc_fly <= pc_q;
            if (redir_take)
                pc_q <= redir_pc_aligned;
            else if (rsp_in_wait)
                pc_q <= pc_fly + XLEN'(4);
            if (rsp_in_wait && !redir_take) begin
                inst_data <= imem_rsp_data;
                inst_pc   <= pc_fly;
            end
        end
    end

    // Next-state: a redirect always wins, but any request already accepted
    // must still have its response drained through DROP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (req_fire)
                    state_d = redir_take ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid)
                    state_d = redir_take ? S_REQ : S_HOLD;
                else if (redir_take)
                    state_d = S_DROP;
            end
            S_HOLD: begin
                if (redir_take || inst_ready)
                    state_d = S_REQ;
            end
            S_DROP: begin
                // A redirect here only retargets pc_q; the owed response is
                // still the one that releases DROP, otherwise we would wait
                // forever for a second response that never comes.
                if (imem_rsp_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage. The reference model is the
// architectural instruction stream: words at consecutive PCs starting from
// the reset PC or the latest accepted redirect target.

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        redirect_misaligned;
`endif

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .redirect_misaligned (redirect_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: the two program words, then a hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    exp_t        sb[$];
    logic [31:0] nxt_pc;
    logic        done;
    int          checks;
    int          failures;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (sb.size() < 4) begin
            sb.push_back('{pc: nxt_pc, data: mem_word(nxt_pc)});
            nxt_pc = nxt_pc + 32'd4;
        end
    endtask

    // Driver: reset, memory responder and random decode/redirect stimulus.
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    logic        acc_s;
    logic [31:0] acc_addr;
    logic        quiet;
    logic        go;
    logic [31:0] tgt;

    initial begin
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; done = 1'b0;
        pend = 1'b0; paddr = '0; cnt = 0;
        nxt_pc = RESET_PC;
        refill();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            acc_s    = imem_req_valid && imem_req_ready && !rst;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            rst            = (c < 3) || (c == 1500) || (c == 1501);
            redirect_valid = 1'b0;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
                sb.delete();
                nxt_pc = RESET_PC;
            end else begin
                quiet = (c < 40) || (c >= 1500 && c < 1520);
                if (acc_s) begin
                    pend  = 1'b1;
                    paddr = acc_addr;
                    cnt   = quiet ? 1 : int'($urandom_range(1, 3));
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                imem_req_ready = quiet ? 1'b1 : ($urandom % 4 != 0);
                inst_ready     = quiet ? 1'b1 : ($urandom % 3 != 0);
                go  = 1'b0;
                tgt = '0;
                if (c == 60) begin
                    go = 1'b1; tgt = 32'hFFFF_FFFC;
                end else if (c == 130) begin
                    go = 1'b1; tgt = 32'h0000_0102;
                end else if (!quiet && ($urandom % 16 == 0)) begin
                    go  = 1'b1;
                    tgt = $urandom & 32'h0000_0FFC;
                    if ($urandom % 4 == 0) tgt = tgt | ($urandom & 32'h3);
                    if ($urandom % 8 == 0) tgt = tgt | 32'hFFFF_FF00;
                end
                if (go) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (tgt[1:0] == 2'b00) begin
                        sb.delete();
                        nxt_pc = tgt;
                    end
`else
                    sb.delete();
                    nxt_pc = tgt & ~32'h3;
`endif
                end
            end
            refill();
        end
        done = 1'b1;
    end

    // Monitor: protocol checks and in-order comparison against the stream.
    int          cyc;
    int          outstanding;
    int          consumed;
    logic        p_rst, p_hold, p_stall, first_pending, mis_exp;
    logic [31:0] p_data, p_pc, p_addr;
    logic        take, acc, cons;
    exp_t        e;

    initial begin
        cyc = 0; outstanding = 0; consumed = 0; checks = 0; failures = 0;
        p_rst = 1'b0; p_hold = 1'b0; p_stall = 1'b0; first_pending = 1'b1; mis_exp = 1'b0;
        p_data = '0; p_pc = '0; p_addr = '0;
    end

    always @(negedge clk) begin
        cyc++;
`ifdef FETCH_MISALIGN_CHECK_EN
        take = redirect_valid && (redirect_pc[1:0] == 2'b00);
        chk("misaligned_flag", 64'(redirect_misaligned), 64'(mis_exp));
        mis_exp = !rst && redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        take = redirect_valid;
`endif
        acc  = imem_req_valid && imem_req_ready;
        cons = inst_valid && inst_ready && !rst && !take;

        if (rst && p_rst) begin
            chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
            chk("rst_inst_valid", 64'(inst_valid), 64'(0));
            chk("rst_inst_data", 64'(inst_data), 64'(0));
            chk("rst_inst_pc", 64'(inst_pc), 64'(0));
            chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
        end

        if (rst) begin
            outstanding   = 0;
            first_pending = 1'b1;
        end else begin
            if (imem_req_valid)
                chk("req_addr_align", 64'(imem_req_addr[1:0]), 64'(0));
            if (inst_valid)
                chk("req_while_holding", 64'(imem_req_valid), 64'(0));
            if (p_hold) begin
                chk("hold_valid", 64'(inst_valid), 64'(1));
                chk("hold_stable", {inst_pc, inst_data}, {p_pc, p_data});
            end
            if (p_stall)
                chk("req_stable", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, p_addr});
            if (acc) begin
                chk("one_outstanding", 64'(outstanding), 64'(0));
                if (first_pending) begin
                    chk("first_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
                    first_pending = 1'b0;
                end
            end
            outstanding = outstanding + (acc ? 1 : 0) - (imem_rsp_valid ? 1 : 0);
            if (cons) begin
                if (sb.size() == 0) begin
                    chk("unexpected_inst", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc_data", {inst_pc, inst_data}, {e.pc, e.data});
                    consumed++;
                end
            end
        end

        p_rst   = rst;
        p_hold  = inst_valid && !inst_ready && !take && !rst;
        p_stall = imem_req_valid && !imem_req_ready && !take && !rst;
        p_data  = inst_data;
        p_pc    = inst_pc;
        p_addr  = imem_req_addr;

        if (done) begin
            chk("progress_min_insts", 64'(consumed >= 100), 64'(1));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

endmodule
